// File: rtl/rv_mmio_uart_tx_if.sv
// Data-memory bus bundle between the core and an MMIO responder.
// master: core side (drives a/we/wd/bytectrl); slave: responder (drives hit/rd).
interface rv_mmio_uart_tx_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] i_mmio_a;
  logic            i_mmio_we;
  logic [XLEN-1:0] i_mmio_wd;
  logic [2:0]      i_mmio_bytectrl;
  logic            o_mmio_hit;
  logic [XLEN-1:0] o_mmio_rd;

  modport master (
    output i_mmio_a, i_mmio_we, i_mmio_wd, i_mmio_bytectrl,
    input  o_mmio_hit, o_mmio_rd
  );

  modport slave (
    input  i_mmio_a, i_mmio_we, i_mmio_wd, i_mmio_bytectrl,
    output o_mmio_hit, o_mmio_rd
  );
endinterface

// File: rtl/rv_mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS/DIV window, byte FIFO, 8N1 serialiser.
// Ports: i_mmio_clk, i_mmio_rst (sync, high), bus (slave), o_mmio_txd, o_mmio_busy.
module rv_mmio_uart_tx #(
  parameter int          XLEN       = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic              i_mmio_clk,
  input  logic              i_mmio_rst,
  rv_mmio_uart_tx_if.slave  bus,
  output logic              o_mmio_txd,
  output logic              o_mmio_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            ovf;
  logic [15:0]     div;
  logic [15:0]     cur_div;
  logic [15:0]     baud;
  logic [2:0]      bit_idx;
  logic [7:0]      sh;

  logic            hit;
  logic [1:0]      off;
  logic            wr;
  logic            full;
  logic            empty;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            bit_end;

  logic unused_bits;
  assign unused_bits = ^{bus.i_mmio_bytectrl, bus.i_mmio_a[1:0],
                         bus.i_mmio_wd[XLEN-1:16]};

  assign hit      = bus.i_mmio_a[XLEN-1:4] == BASE_ADDR[XLEN-1:4];
  assign off      = bus.i_mmio_a[3:2];
  assign wr       = bus.i_mmio_we & hit;
  assign full     = count == CW'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign push_req = wr & (off == 2'd0);
  assign push     = push_req & ~full;

  // cur_div is latched at every bit boundary so a DIV write mid-bit
  // never stretches or truncates the bit in flight.
  assign bit_end  = baud == (cur_div - 16'd1);
  assign pop      = ~empty & ((state == IDLE) |
                              ((state == STOP) & bit_end));

  always_comb begin
    bus.o_mmio_rd = '0;
    if (hit) begin
      unique case (off)
        2'd1: begin
          bus.o_mmio_rd[0]    = full;
          bus.o_mmio_rd[1]    = empty;
          bus.o_mmio_rd[2]    = state != IDLE;
          bus.o_mmio_rd[3]    = ovf;
          bus.o_mmio_rd[11:8] = 4'(count);
        end
        2'd2:    bus.o_mmio_rd[15:0] = div;
        default: bus.o_mmio_rd = '0;
      endcase
    end
  end

  assign bus.o_mmio_hit = hit;

  always_ff @(posedge i_mmio_clk) begin
    if (push) mem[wptr] <= bus.i_mmio_wd[7:0];
  end

  always_ff @(posedge i_mmio_clk) begin
    if (i_mmio_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      div   <= DIV_RESET;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req & full)
        ovf <= 1'b1;
      else if (wr & (off == 2'd1) & bus.i_mmio_wd[3])
        ovf <= 1'b0;
      if (wr & (off == 2'd2))
        div <= (bus.i_mmio_wd[15:0] == '0) ? 16'd1
                                           : bus.i_mmio_wd[15:0];
    end
  end

  always_ff @(posedge i_mmio_clk) begin
    if (i_mmio_rst) begin
      state       <= IDLE;
      o_mmio_txd  <= 1'b1;
      o_mmio_busy <= 1'b0;
      cur_div     <= DIV_RESET;
      baud        <= '0;
      bit_idx     <= '0;
      sh          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          o_mmio_txd <= 1'b1;
          if (!empty) begin
            sh          <= mem[rptr];
            state       <= START;
            baud        <= '0;
            cur_div     <= div;
            o_mmio_txd  <= 1'b0;
            o_mmio_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud       <= '0;
            cur_div    <= div;
            bit_idx    <= '0;
            state      <= DATA;
            o_mmio_txd <= sh[0];
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud    <= '0;
            cur_div <= div;
            if (bit_idx == 3'd7) begin
              state      <= STOP;
              o_mmio_txd <= 1'b1;
            end else begin
              bit_idx    <= bit_idx + 3'd1;
              sh         <= sh >> 1;
              o_mmio_txd <= sh[1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud    <= '0;
            cur_div <= div;
            if (!empty) begin
              sh         <= mem[rptr];
              state      <= START;
              o_mmio_txd <= 1'b0;
            end else begin
              state       <= IDLE;
              o_mmio_busy <= 1'b0;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_mmio_uart_tx.sv
// Directed self-checking bench for rv_mmio_uart_tx.
// Drives and samples on the falling clock edge; a monitor decodes frames.
module tb_rv_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   mon_div = 868;
  logic [7:0] rxq [$];

  rv_mmio_uart_tx_if #(.XLEN(32)) bus ();

  rv_mmio_uart_tx dut (
    .i_mmio_clk  (clk),
    .i_mmio_rst  (rst),
    .bus         (bus.slave),
    .o_mmio_txd  (txd),
    .o_mmio_busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    logic [7:0] b;
    int d;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        d = mon_div;
        repeat (d / 2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (d) @(negedge clk);
          b[j] = txd;
        end
        repeat (d) @(negedge clk);
        rxq.push_back(b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bus.i_mmio_a  = addr;
    bus.i_mmio_wd = data;
    bus.i_mmio_we = 1'b1;
    @(negedge clk);
    bus.i_mmio_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr,
                        input logic [31:0] exp);
    bus.i_mmio_a = addr;
    #1;
    check(tag, bus.o_mmio_rd, exp);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] b,
                              input int div);
    logic e;
    int   idx;
    for (int i = 0; i < 10 * div; i++) begin
      idx = i / div;
      if (idx == 0)      e = 1'b0;
      else if (idx == 9) e = 1'b1;
      else               e = b[idx-1];
      check(tag, {31'd0, txd}, {31'd0, e});
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bus.i_mmio_a        = BASE + 32'h4;
    bus.i_mmio_we       = 1'b0;
    bus.i_mmio_wd       = '0;
    bus.i_mmio_bytectrl = 3'b010;
    repeat (2) @(negedge clk);

    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hit", {31'd0, bus.o_mmio_hit}, 32'd1);
    rd_chk("rst_status", BASE + 32'h4, 32'h2);
    rd_chk("rst_div", BASE + 32'h8, 32'd868);
    rd_chk("txdata_rd", BASE + 32'h0, 32'h0);
    rd_chk("off_c_rd", BASE + 32'hC, 32'h0);
    rst = 1'b0;

    store(BASE + 32'h8, 32'd4);
    mon_div = 4;
    rd_chk("div4", BASE + 32'h8, 32'd4);
    store(BASE + 32'h0, 32'hFFFF_FFA5);
    rd_chk("sf_count1", BASE + 32'h4, 32'h100);
    check("sf_txd_pre", {31'd0, txd}, 32'd1);
    @(negedge clk);
    check("sf_busy_on", {31'd0, busy}, 32'd1);
    expect_frame("sf_bit", 8'hA5, 4);
    check("sf_busy_off", {31'd0, busy}, 32'd0);

    store(BASE + 32'h8, 32'd2);
    mon_div = 2;
    store(BASE + 32'h0, 32'h01);
    store(BASE + 32'h0, 32'h80);
    rd_chk("b2b_count1", BASE + 32'h4, 32'h104);
    expect_frame("b2b_f1", 8'h01, 2);
    rd_chk("b2b_count0", BASE + 32'h4, 32'h006);
    expect_frame("b2b_f2", 8'h80, 2);
    check("b2b_busy_off", {31'd0, busy}, 32'd0);
    rd_chk("b2b_status", BASE + 32'h4, 32'h2);

    rxq.delete();
    store(BASE + 32'h8, 32'd100);
    mon_div = 100;
    for (int i = 0; i < 6; i++) store(BASE + 32'h0, 32'h11 + i);
    rd_chk("ovf_status", BASE + 32'h4, 32'h40D);
    store(BASE + 32'h4, 32'h8);
    rd_chk("ovf_clear", BASE + 32'h4, 32'h405);
    wait_idle(6000);
    repeat (4) @(negedge clk);
    check("ovf_nbytes", rxq.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < rxq.size())
        check("ovf_byte", {24'd0, rxq[i]}, 32'h11 + i);
    end

    store(BASE + 32'h8, 32'd0);
    mon_div = 1;
    rd_chk("div0_reads1", BASE + 32'h8, 32'd1);
    store(BASE + 32'h0, 32'h55);
    @(negedge clk);
    expect_frame("div1_bit", 8'h55, 1);
    check("div1_busy_off", {31'd0, busy}, 32'd0);

    store(BASE + 32'h8, 32'd4);
    mon_div = 4;
    store(BASE + 32'h0, 32'hAA);
    store(BASE + 32'h0, 32'hBB);
    store(BASE + 32'h0, 32'hCC);
    repeat (5) @(negedge clk);
    rd_chk("mid_status", BASE + 32'h4, 32'h204);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_txd", {31'd0, txd}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    rd_chk("mid_rst_status", BASE + 32'h4, 32'h2);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_txd", {31'd0, txd}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    bus.i_mmio_a = BASE + 32'h10;
    #1;
    check("dec_hit", {31'd0, bus.o_mmio_hit}, 32'd0);
    check("dec_rd", bus.o_mmio_rd, 32'd0);
    store(BASE + 32'h18, 32'd7);
    store(BASE + 32'h10, 32'h5A);
    rd_chk("dec_div", BASE + 32'h8, 32'd868);
    rd_chk("dec_status", BASE + 32'h4, 32'h2);
    @(negedge clk);
    check("dec_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
